// File: rtl/jam_search.sv
// Exhaustive job-assignment search: walks all N! worker->job permutations in lexicographic order.
// Optional JAM_BEST_PERM_EN adds a BestPerm output holding the first minimum-cost permutation.
module jam_search #(
    parameter int N   = 8,
    parameter int IW  = 3,
    parameter int CW  = 7,
    parameter int SW  = 10,
    parameter int MCW = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    output logic [IW-1:0]    W,
    output logic [IW-1:0]    J,
    input  logic [CW-1:0]    Cost,
    output logic             BUSY,
    output logic             Valid,
    output logic [SW-1:0]    MinCost,
    output logic [MCW-1:0]   MatchCount
`ifdef JAM_BEST_PERM_EN
    ,
    output logic [N*IW-1:0]  BestPerm
`endif
);

    typedef enum logic [2:0] {IDLE, INIT, ACC, CMP, NEXT, DONE} state_t;
    typedef logic [N-1:0][IW-1:0] perm_t;

    state_t         state, state_n;
    perm_t          perm, perm_nxt;
    logic [IW-1:0]  k;
    logic [IW-1:0]  w_q, j_q, jsel;
    logic [SW-1:0]  sum, best, best_n;
    logic [MCW-1:0] cnt, cnt_n;
    logic           last;
`ifdef JAM_BEST_PERM_EN
    perm_t          bperm, bperm_n;
`endif

    function automatic perm_t ident_perm();
        perm_t r;
        for (int a = 0; a < N; a++) r[a] = IW'(a);
        return r;
    endfunction

    // Final permutation of the walk is the strictly descending one.
    function automatic logic is_last(input perm_t p);
        logic r;
        r = 1'b1;
        for (int a = 0; a < N-1; a++)
            if (p[a] <= p[a+1]) r = 1'b0;
        return r;
    endfunction

    // Lexicographic successor, built so every array index is a loop constant.
    function automatic perm_t next_perm(input perm_t p);
        perm_t         s, r;
        int            piv, swp;
        logic [IW-1:0] vp, vs;
        piv = 0;
        swp = 0;
        vp  = '0;
        vs  = '0;
        for (int a = 0; a < N-1; a++)
            if (p[a] < p[a+1]) piv = a;
        for (int a = 0; a < N; a++)
            if (a == piv) vp = p[a];
        for (int a = 0; a < N; a++)
            if (a > piv && p[a] > vp) swp = a;
        for (int a = 0; a < N; a++)
            if (a == swp) vs = p[a];
        for (int a = 0; a < N; a++)
            s[a] = (a == piv) ? vs : (a == swp) ? vp : p[a];
        r = s;
        for (int a = 0; a < N; a++)
            for (int b = 0; b < N; b++)
                if (a > piv && b == N + piv - a) r[a] = s[b];
        return r;
    endfunction

    assign perm_nxt = next_perm(perm);
    assign last     = is_last(perm);

    always_comb begin
        jsel = '0;
        for (int a = 0; a < N; a++)
            if (k == IW'(a)) jsel = perm[a];
    end

    assign W     = (state == ACC) ? k    : w_q;
    assign J     = (state == ACC) ? jsel : j_q;
    assign BUSY  = (state == INIT) || (state == ACC) || (state == CMP) || (state == NEXT);
    assign Valid = (state == DONE);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (START) state_n = INIT;
            INIT:    state_n = ACC;
            ACC:     if (k == IW'(N-1)) state_n = CMP;
            CMP:     state_n = last ? DONE : NEXT;
            NEXT:    state_n = ACC;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // cnt==0 marks the first compare, so a sum equal to the all-ones seed still counts as a new best.
    always_comb begin
        best_n  = best;
        cnt_n   = cnt;
`ifdef JAM_BEST_PERM_EN
        bperm_n = bperm;
`endif
        if (sum < best || cnt == '0) begin
            best_n  = sum;
            cnt_n   = MCW'(1);
`ifdef JAM_BEST_PERM_EN
            bperm_n = perm;
`endif
        end else if (sum == best && cnt != '1) begin
            cnt_n = cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            perm       <= '0;
            k          <= '0;
            w_q        <= '0;
            j_q        <= '0;
            sum        <= '0;
            best       <= '0;
            cnt        <= '0;
            MinCost    <= '0;
            MatchCount <= '0;
`ifdef JAM_BEST_PERM_EN
            bperm      <= '0;
            BestPerm   <= '0;
`endif
        end else begin
            case (state)
                INIT: begin
                    perm <= ident_perm();
                    k    <= '0;
                    sum  <= '0;
                    best <= '1;
                    cnt  <= '0;
                end
                ACC: begin
                    sum <= sum + SW'(Cost);
                    w_q <= k;
                    j_q <= jsel;
                    k   <= k + 1'b1;
                end
                CMP: begin
                    best  <= best_n;
                    cnt   <= cnt_n;
                    sum   <= '0;
                    k     <= '0;
`ifdef JAM_BEST_PERM_EN
                    bperm <= bperm_n;
`endif
                    // Results land on the DONE entry edge so they are live while Valid is high.
                    if (last) begin
                        MinCost    <= best_n;
                        MatchCount <= cnt_n;
`ifdef JAM_BEST_PERM_EN
                        BestPerm   <= bperm_n;
`endif
                    end
                end
                NEXT:    perm <= perm_nxt;
                default: ;
            endcase
        end
    end

endmodule
